// File: rtl/tag_arbiter_pkg.sv
// Shared definitions for the tag arbiter: parameter defaults, match-result field layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tag_arb_pkg;

    localparam int NREQ_DEFAULT  = 4;
    localparam int TAG_W_DEFAULT = 10;

    // Match-result field layout inside the 10-bit payload
    localparam int TAG_LSB    = 0;
    localparam int TAG_W_F    = 6;
    localparam int IN_IF_LSB  = 6;
    localparam int OUT_IF_LSB = 8;
    localparam int IF_W       = 2;

    typedef struct packed {
        logic [IF_W-1:0]    out_if;
        logic [IF_W-1:0]    in_if;
        logic [TAG_W_F-1:0] tag;
    } match_t;

endpackage

// File: rtl/tag_arbiter_rr_pick.sv
// Rotating priority encoder: first set valid bit searching upward from base, modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the result.
//
// Ports:
//   valid  - request bits
//   base   - index searched first
//   any    - at least one valid bit set
//   winner - chosen index (equals base when nothing is valid)
module rr_pick #(
    parameter int  N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] base,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    // N is a power of two, so IDX_W-bit addition wraps modulo N for free.
    // Scanning from the farthest offset down leaves the nearest hit in winner.
    always_comb begin
        any    = |valid;
        winner = base;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[base + IDX_W'(k)]) begin
                winner = base + IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/tag_arbiter.sv
// Round-robin merge of NREQ match-result streams into one registered tagin stream.
// Latency: one cycle from accepted request to tagin_valid; one result per cycle sustained.
// Backpressure: tagin_valid && !tagin_ready holds the output and drops every req_ready.
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   req_data/req_valid      - per-requester match result and valid
//   req_ready               - per-requester accept, one-hot or zero, combinational
//   tagin_data/valid/ready  - registered output stream towards pmem_group
//   grant_id                - index of the requester that produced tagin_data
//   grant_count/stall_count - saturating statistics, only with TAG_ARB_STATS_EN defined
module tag_arbiter
    import tag_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NREQ-1:0][TAG_W-1:0]  req_data,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    output logic [TAG_W-1:0]            tagin_data,
    output logic                        tagin_valid,
    input  logic                        tagin_ready,
    output logic [$clog2(NREQ)-1:0]     grant_id
`ifdef TAG_ARB_STATS_EN
    ,
    output logic [NREQ-1:0][15:0]       grant_count,
    output logic [15:0]                 stall_count
`endif
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic             any;
    logic             load;
    logic             accept;

    rr_pick #(.N(NREQ)) u_pick (
        .valid  (req_valid),
        .base   (rr_ptr),
        .any    (any),
        .winner (winner)
    );

    // Output register is free when empty or being drained this cycle.
    assign load   = !tagin_valid || tagin_ready;
    assign accept = load && any && reset;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tagin_valid <= 1'b0;
            tagin_data  <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            if (any) begin
                tagin_valid <= 1'b1;
                tagin_data  <= req_data[winner];
                grant_id    <= winner;
                rr_ptr      <= winner + IDX_W'(1);
            end else begin
                tagin_valid <= 1'b0;
            end
        end
    end

`ifdef TAG_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_count <= '0;
            stall_count <= '0;
        end else begin
            if (accept && (grant_count[winner] != 16'hFFFF)) begin
                grant_count[winner] <= grant_count[winner] + 16'd1;
            end
            if (tagin_valid && !tagin_ready && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tag_arbiter.sv
// Directed bench for tag_arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Counter checks are compiled only when TAG_ARB_STATS_EN is defined.
module tb_tag_arbiter;
    import tag_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int TAG_W = 10;

    logic                       clock;
    logic                       reset;
    logic [NREQ-1:0][TAG_W-1:0] req_data;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [TAG_W-1:0]           tagin_data;
    logic                       tagin_valid;
    logic                       tagin_ready;
    logic [1:0]                 grant_id;
`ifdef TAG_ARB_STATS_EN
    logic [NREQ-1:0][15:0]      grant_count;
    logic [15:0]                stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    tag_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .tagin_data  (tagin_data),
        .tagin_valid (tagin_valid),
        .tagin_ready (tagin_ready),
        .grant_id    (grant_id)
`ifdef TAG_ARB_STATS_EN
        ,
        .grant_count (grant_count),
        .stall_count (stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    logic [TAG_W-1:0] d [NREQ];
    match_t           m;
    logic [1:0]       exp_id;

    initial begin
        d[0] = 10'h101;
        d[1] = 10'h0A2;
        d[2] = 10'h233;
        d[3] = 10'h3C4;
        m = '{out_if: 2'd1, in_if: 2'd2, tag: 6'h25};   // 10'h1A5

        // Reset state, with requests present and downstream ready
        reset       = 1'b0;
        req_valid   = 4'hF;
        tagin_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) req_data[i] = d[i];
        #3;
        check("rst_valid", 32'(tagin_valid), 32'd0);
        check("rst_data",  32'(tagin_data),  32'd0);
        check("rst_id",    32'(grant_id),    32'd0);
        check("rst_ready", 32'(req_ready),   32'd0);
        tick();
        tick();
        check("rst_hold_valid", 32'(tagin_valid), 32'd0);
        req_valid = '0;
        reset     = 1'b1;
        tick();

        // Single requester 2
        req_data[2] = TAG_W'(m);
        req_valid   = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'h4);
        tick();
        check("single_valid", 32'(tagin_valid), 32'd1);
        check("single_data",  32'(tagin_data),  32'h1A5);
        check("single_id",    32'(grant_id),    32'd2);
        // Pointer now sits at 3: with everyone valid, 3 wins, then wrap to 0
        req_data[2] = d[2];
        req_valid   = 4'hF;
        #1;
        check("ptr3_ready", 32'(req_ready), 32'h8);
        tick();
        check("ptr3_id",   32'(grant_id),   32'd3);
        check("ptr3_data", 32'(tagin_data), 32'h3C4);
        check("wrap_ready", 32'(req_ready), 32'h1);
        req_valid = '0;
        tick();
        check("idle_valid", 32'(tagin_valid), 32'd0);
        check("idle_id",    32'(grant_id),    32'd3);
        check("idle_data",  32'(tagin_data),  32'h3C4);

        // All requesters continuously valid from reset: 0,1,2,3,0,1
        pulse_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            tick();
            exp_id = 2'(c % 4);
            check("rr_valid", 32'(tagin_valid), 32'd1);
            check("rr_id",    32'(grant_id),    32'(exp_id));
            check("rr_data",  32'(tagin_data),  32'(d[exp_id]));
        end

        // Backpressure for 5 cycles on the result from requester 1
        tagin_ready = 1'b0;
        #1;
        check("bp_ready0", 32'(req_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_valid", 32'(tagin_valid), 32'd1);
            check("bp_id",    32'(grant_id),    32'd1);
            check("bp_data",  32'(tagin_data),  32'h0A2);
            check("bp_ready", 32'(req_ready),   32'd0);
        end
`ifdef TAG_ARB_STATS_EN
        check("bp_stall_count", 32'(stall_count), 32'd5);
`endif

        // Drain plus load: pointer is 2, only requester 1 valid, new payload
        req_valid   = 4'b0010;
        req_data[1] = 10'h2C3;
        tagin_ready = 1'b1;
        #1;
        check("dl_ready", 32'(req_ready), 32'h2);
        tick();
        check("dl_valid", 32'(tagin_valid), 32'd1);
        check("dl_id",    32'(grant_id),    32'd1);
        check("dl_data",  32'(tagin_data),  32'h2C3);

        // Reset in the middle of a stall
        req_valid   = '0;
        tagin_ready = 1'b0;
        tick();
        check("rs_held", 32'(tagin_valid), 32'd1);
        #2;
        req_valid   = 4'hF;
        tagin_ready = 1'b1;
        reset       = 1'b0;
        #1;
        check("rs_async_valid", 32'(tagin_valid), 32'd0);
        check("rs_async_data",  32'(tagin_data),  32'd0);
        check("rs_async_id",    32'(grant_id),    32'd0);
        check("rs_ready",       32'(req_ready),   32'd0);
        #2;
        reset     = 1'b1;
        req_valid = 4'b1010;
        #1;
        check("rs_first_ready", 32'(req_ready), 32'h2);
        tick();
        check("rs_first_id",   32'(grant_id),   32'd1);
        check("rs_first_data", 32'(tagin_data), 32'h2C3);

`ifdef TAG_ARB_STATS_EN
        // Saturation of requester 0's grant counter
        req_valid = '0;
        pulse_reset();
        req_valid = 4'b0001;
        for (int c = 0; c < 65540; c++) tick();
        check("sat_grant0", 32'(grant_count[0]), 32'hFFFF);
        check("sat_grant1", 32'(grant_count[1]), 32'd0);
        check("sat_stall",  32'(stall_count),    32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_arbiter.md
# tag_arbiter

Round-robin arbiter that merges match-result streams from NREQ independent requesters (parsers/matchers, one per ingress interface) into the single `tagin` valid/ready stream consumed by `pmem_group`. Each request carries a 10-bit match result: tag [5:0], input interface [7:6], output interface [9:8]. The output stage is registered and supports a one-result-per-cycle sustained rate. Round-robin priority bounds each requester's wait at NREQ-1 grants.

## Interface
Parameters:
- `NREQ`, 4, number of requesters; must be a power of two, 2..8.
- `TAG_W`, 10, width of each match result.

Ports:
- `clock`  in  1  single clock; all state is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_data`  in  [TAG_W-1:0] x [NREQ-1:0]  per-requester match result.
- `req_valid`  in  1 x [NREQ-1:0]  per-requester valid.
- `req_ready`  out  1 x [NREQ-1:0]  per-requester accept; combinational; one-hot or zero.
- `tagin_data`  out  TAG_W  registered result to `pmem_group`.
- `tagin_valid`  out  1  registered valid.
- `tagin_ready`  in  1  downstream accept.
- `grant_id`  out  log2(NREQ)  registered index of the requester whose result is in `tagin_data`.
- `grant_count`  out  16 x [NREQ-1:0]  per-requester accepted count. Present only with `TAG_ARB_STATS_EN`.
- `stall_count`  out  16  cycles with `tagin_valid && !tagin_ready`. Present only with `TAG_ARB_STATS_EN`.

## Operation
- State: output register (`tagin_valid`, `tagin_data`, `grant_id`) and round-robin pointer `rr_ptr` (log2(NREQ) bits).
- Load enable: `load = !tagin_valid || tagin_ready`.
- Pick: winner `w` is the first `i` with `req_valid[i]` set, searching `rr_ptr`, `rr_ptr+1`, … modulo NREQ.
- Ready: `req_ready[w] = load` when any request is valid; all other `req_ready` bits are 0.
- Accepted grant (`load` and any `req_valid`): on the next edge, `tagin_data <= req_data[w]`, `grant_id <= w`, `tagin_valid <= 1`, `rr_ptr <= (w+1) mod NREQ`.
- Load with no request valid: `tagin_valid <= 0`; `tagin_data`, `grant_id` and `rr_ptr` hold.
- Stall (`tagin_valid && !tagin_ready`): all output registers and `rr_ptr` hold; all `req_ready` are 0.
- Payload is passed through unmodified; no field checking.
- Requesters must hold `req_valid`/`req_data` stable until accepted. The arbiter never withdraws a grant except on reset.

## Timing
- Latency: request accepted on edge N → `tagin_valid` high from N through at least the next cycle.
- Throughput: 1 result/cycle while `tagin_ready` stays high.
- `req_ready` depends combinationally on `tagin_ready`, `tagin_valid`, `req_valid` and `rr_ptr`. There is no combinational path from `req_data`.
- Reset (asynchronous assert, synchronous deassert expected upstream): `tagin_valid=0`, `tagin_data=0`, `grant_id=0`, `rr_ptr=0`, counters 0.
  - While `reset` is low, all `req_ready` are forced to 0.
  - Reset mid-transfer discards the held result.
- Simultaneous drain and new grant in one cycle: the old result leaves and the new result loads on the same edge, with no bubble.
- `rr_ptr` wraps from NREQ-1 to 0.
- Counters (when present) saturate at 16'hFFFF and do not wrap.

## Configuration
- `TAG_ARB_STATS_EN` defined:
  - `grant_count[i]` increments on each accepted grant to requester `i`.
  - `stall_count` increments on each stall cycle.
  - Both saturate and clear only on reset.
- `TAG_ARB_STATS_EN` undefined: counter ports and logic are absent; arbitration behaviour is identical.

## Structure
- Shared package `tag_arb_pkg` holds:
  - `NREQ` and `TAG_W` defaults.
  - Field localparams: `TAG_LSB=0`, `TAG_W_F=6`, `IN_IF_LSB=6`, `OUT_IF_LSB=8`, `IF_W=2`.
  - Typedef `match_t` (packed struct: `out_if`, `in_if`, `tag`).
- One sub-module, `rr_pick`: combinational rotate-priority-encode over NREQ valid bits from a base pointer, outputting `any` and `winner`. It is instantiated once.

## Test plan
- Single requester: `req_valid[2]=1` with data 10'h1A5, `tagin_ready=1` → `req_ready[2]` high that cycle; next cycle `tagin_data=10'h1A5`, `grant_id=2`, `tagin_valid=1`; `rr_ptr=3`.
- All four requesters valid continuously, `tagin_ready=1`, from reset → `grant_id` sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Backpressure: result held, `tagin_ready=0` for 5 cycles → `tagin_data`/`grant_id` stable and all `req_ready=0` for 5 cycles; `stall_count=5` with stats enabled.
- Drain plus load: `tagin_valid=1`, `tagin_ready=1`, `req_valid[1]=1` → old result is consumed and the new result from requester 1 is presented on the next cycle.
- Reset mid-stall: assert `reset` low while `tagin_valid=1` → `tagin_valid` drops immediately and asynchronously; after release the first grant goes to lowest-index valid requester (`rr_ptr=0`).
- Saturation (stats enabled): 65 540 grants to requester 0 → `grant_count[0]=16'hFFFF`.
